// File: rtl/projectile_pool_if.sv
// Bundles the projectile pool's control inputs and per-slot outputs.
// Master drives fire/tick/hit; slave (the pool) drives slot state and status pulses.
interface projectile_pool_if #(
   parameter int N_PROJ  = 4,
   parameter int COORD_W = 10
);
   localparam int IDX_W = $clog2(N_PROJ);
   localparam int CNT_W = $clog2(N_PROJ + 1);

   logic                        tick_move;
   logic                        fire_req;
   logic [COORD_W-1:0]          ship_x;
   logic                        hit_valid;
   logic [IDX_W-1:0]            hit_idx;
   logic [N_PROJ-1:0]           proj_valid;
   logic [N_PROJ*COORD_W-1:0]   proj_x;
   logic [N_PROJ*COORD_W-1:0]   proj_y;
   logic                        fire_accepted;
   logic                        fire_dropped;
   logic [CNT_W-1:0]            active_count;

   modport master (
      output tick_move, fire_req, ship_x, hit_valid, hit_idx,
      input  proj_valid, proj_x, proj_y, fire_accepted, fire_dropped, active_count
   );

   modport slave (
      input  tick_move, fire_req, ship_x, hit_valid, hit_idx,
      output proj_valid, proj_x, proj_y, fire_accepted, fire_dropped, active_count
   );
endinterface

// File: rtl/projectile_pool.sv
// Slot pool of player projectiles: spawns at the muzzle, climbs on tick_move, retires on top edge or hit.
// Slot state and pulses update one cycle after inputs; no backpressure, a rejected fire edge is simply dropped.
module projectile_pool #(
   parameter int N_PROJ    = 4,
   parameter int COORD_W   = 10,
   parameter int SHIP_Y    = 440,
   parameter int SHIP_W    = 32,
   parameter int PROJ_STEP = 4,
   parameter int COOLDOWN  = 8
) (
   input  logic              clk_master,
   input  logic              d_reset_n,
   projectile_pool_if.slave  bus
);
   localparam int IDX_W = $clog2(N_PROJ);
   localparam int CNT_W = $clog2(N_PROJ + 1);
   localparam int CD_W  = $clog2(COOLDOWN + 1);

   localparam logic [COORD_W-1:0] HALF_W  = COORD_W'(SHIP_W / 2);
   localparam logic [COORD_W-1:0] STEP    = COORD_W'(PROJ_STEP);
   localparam logic [COORD_W-1:0] SPAWN_Y = COORD_W'(SHIP_Y);
   localparam logic [CD_W-1:0]    CD_LOAD = CD_W'(COOLDOWN);

   logic [N_PROJ-1:0]               valid_q, valid_d;
   logic [N_PROJ-1:0][COORD_W-1:0]  x_q, x_d;
   logic [N_PROJ-1:0][COORD_W-1:0]  y_q, y_d;
   logic [CD_W-1:0]                 cd_q, cd_d;
   logic                            fire_q, fire_d;
   logic                            arm_q, arm_d;
   logic                            acc_q, acc_d;
   logic                            drop_q, drop_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;

   logic             fire_edge;
   logic             hit_ok;
   logic             free_found;
   logic [IDX_W-1:0] free_idx;
   logic             accept;

   always_comb begin
      valid_d = valid_q;
      x_d     = x_q;
      y_d     = y_q;
      cd_d    = cd_q;
      cnt_d   = '0;
      fire_d  = bus.fire_req;
      // A button held through reset release must be let go once before it can fire.
      arm_d   = arm_q | ~bus.fire_req;

      fire_edge  = bus.fire_req & ~fire_q & arm_q;
      hit_ok     = bus.hit_valid && (int'(bus.hit_idx) < N_PROJ);
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = 0; i < N_PROJ; i++) begin
         if (!valid_q[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
      accept = fire_edge && (cd_q == '0) && free_found;

      for (int i = 0; i < N_PROJ; i++) begin
         if (valid_q[i]) begin
            if (hit_ok && (bus.hit_idx == IDX_W'(i))) begin
               valid_d[i] = 1'b0;
            end else if (bus.tick_move) begin
               if (y_q[i] < STEP) valid_d[i] = 1'b0;
               else               y_d[i]     = y_q[i] - STEP;
            end
         end
      end

      // The spawn target comes from the pre-cycle free mask, so it never collides with a moving slot.
      if (accept) begin
         valid_d[free_idx] = 1'b1;
         x_d[free_idx]     = bus.ship_x + HALF_W;
         y_d[free_idx]     = SPAWN_Y;
      end

      if (accept)                            cd_d = CD_LOAD;
      else if (bus.tick_move && cd_q != '0)  cd_d = cd_q - 1'b1;

      acc_d  = accept;
      drop_d = fire_edge && !accept;

      for (int i = 0; i < N_PROJ; i++) begin
         cnt_d = cnt_d + CNT_W'(valid_q[i]);
      end
   end

   always_ff @(posedge clk_master or negedge d_reset_n) begin
      if (!d_reset_n) begin
         valid_q <= '0;
         x_q     <= '0;
         y_q     <= '0;
         cd_q    <= '0;
         fire_q  <= 1'b0;
         arm_q   <= 1'b0;
         acc_q   <= 1'b0;
         drop_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         x_q     <= x_d;
         y_q     <= y_d;
         cd_q    <= cd_d;
         fire_q  <= fire_d;
         arm_q   <= arm_d;
         acc_q   <= acc_d;
         drop_q  <= drop_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.proj_valid    = valid_q;
   assign bus.proj_x        = x_q;
   assign bus.proj_y        = y_q;
   assign bus.fire_accepted = acc_q;
   assign bus.fire_dropped  = drop_q;
   assign bus.active_count  = cnt_q;
endmodule

// File: tb/tb_projectile_pool.sv
// Directed stimulus pushes expected pulses and slot snapshots into queues; a negedge monitor pops and compares.
module tb_projectile_pool;
   logic clk_master = 1'b0;
   logic d_reset_n  = 1'b0;

   always #5 clk_master = ~clk_master;

   projectile_pool_if #(.N_PROJ(4), .COORD_W(10)) bus ();

   projectile_pool #(
      .N_PROJ(4), .COORD_W(10), .SHIP_Y(440), .SHIP_W(32), .PROJ_STEP(4), .COOLDOWN(8)
   ) dut (
      .clk_master (clk_master),
      .d_reset_n  (d_reset_n),
      .bus        (bus)
   );

   typedef struct {
      logic [3:0] mask;
      logic [2:0] cnt;
      int         slot;
      logic [9:0] x;
      logic [9:0] y;
   } snap_t;

   bit    pulse_q[$];
   snap_t snap_q[$];
   int    n_cmp = 0;
   int    n_bad = 0;

   always @(negedge clk_master) begin
      if (bus.fire_accepted || bus.fire_dropped) begin
         n_cmp++;
         if (pulse_q.size() == 0) begin
            n_bad++;
            $display("FAIL pulse_unexpected: got acc=%0b drop=%0b, required none", bus.fire_accepted, bus.fire_dropped);
         end else begin
            automatic bit acc = pulse_q.pop_front();
            if (bus.fire_accepted != acc || bus.fire_dropped != !acc) begin
               n_bad++;
               $display("FAIL pulse_kind: got acc=%0b drop=%0b, required acc=%0b drop=%0b",
                        bus.fire_accepted, bus.fire_dropped, acc, !acc);
            end
         end
      end
      if (snap_q.size() != 0) begin
         automatic snap_t e = snap_q.pop_front();
         automatic logic [9:0] ax = bus.proj_x[e.slot*10 +: 10];
         automatic logic [9:0] ay = bus.proj_y[e.slot*10 +: 10];
         n_cmp += 4;
         if (bus.proj_valid !== e.mask) begin
            n_bad++;
            $display("FAIL proj_valid: got %b, required %b", bus.proj_valid, e.mask);
         end
         if (bus.active_count !== e.cnt) begin
            n_bad++;
            $display("FAIL active_count: got %0d, required %0d", bus.active_count, e.cnt);
         end
         if (ax !== e.x) begin
            n_bad++;
            $display("FAIL proj_x[%0d]: got %0d, required %0d", e.slot, ax, e.x);
         end
         if (ay !== e.y) begin
            n_bad++;
            $display("FAIL proj_y[%0d]: got %0d, required %0d", e.slot, ay, e.y);
         end
      end
   end

   task automatic cyc();
      @(posedge clk_master);
      #1;
   endtask

   task automatic snap(input logic [3:0] mask, input logic [2:0] cnt, input int slot,
                       input logic [9:0] x, input logic [9:0] y);
      snap_t e;
      e.mask = mask; e.cnt = cnt; e.slot = slot; e.x = x; e.y = y;
      snap_q.push_back(e);
      cyc();
   endtask

   task automatic fire_shot(input bit acc);
      pulse_q.push_back(acc);
      bus.fire_req = 1'b1;
      cyc();
      bus.fire_req = 1'b0;
   endtask

   task automatic tick(input int n);
      bus.tick_move = 1'b1;
      repeat (n) cyc();
      bus.tick_move = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.tick_move = 1'b0;
      bus.fire_req  = 1'b0;
      bus.ship_x    = 10'd100;
      bus.hit_valid = 1'b0;
      bus.hit_idx   = 2'd0;
      repeat (2) cyc();
      snap(4'b0000, 3'd0, 0, 10'd0, 10'd0);
      d_reset_n = 1'b1;
      cyc();

      // single shot: x = 100 + 16, y = 440; count lags by one cycle
      fire_shot(1'b1);
      snap(4'b0001, 3'd0, 0, 10'd116, 10'd440);
      snap(4'b0001, 3'd1, 0, 10'd116, 10'd440);

      // three ticks climb 12 px; cooldown still 5 so the next edge drops
      tick(3);
      snap(4'b0001, 3'd1, 0, 10'd116, 10'd428);
      fire_shot(1'b0);
      snap(4'b0001, 3'd1, 0, 10'd116, 10'd428);
      tick(5);

      // fill all four slots, one cooldown apart
      fire_shot(1'b1);
      snap(4'b0011, 3'd1, 1, 10'd116, 10'd440);
      tick(8);
      fire_shot(1'b1);
      snap(4'b0111, 3'd2, 2, 10'd116, 10'd440);
      tick(8);
      bus.ship_x = 10'd200;
      fire_shot(1'b1);
      snap(4'b1111, 3'd3, 3, 10'd216, 10'd440);
      tick(8);
      fire_shot(1'b0);
      snap(4'b1111, 3'd4, 0, 10'd116, 10'd312);

      // hit + tick on slot1 with a fire edge: slot1 cleared unmoved, shot dropped
      pulse_q.push_back(1'b0);
      bus.hit_valid = 1'b1;
      bus.hit_idx   = 2'd1;
      bus.tick_move = 1'b1;
      bus.fire_req  = 1'b1;
      cyc();
      bus.hit_valid = 1'b0;
      bus.tick_move = 1'b0;
      bus.fire_req  = 1'b0;
      snap(4'b1101, 3'd4, 1, 10'd116, 10'd344);
      snap(4'b1101, 3'd3, 0, 10'd116, 10'd308);
      snap(4'b1101, 3'd3, 3, 10'd216, 10'd404);

      // hit on an empty slot is ignored
      bus.hit_valid = 1'b1;
      bus.hit_idx   = 2'd1;
      cyc();
      bus.hit_valid = 1'b0;
      snap(4'b1101, 3'd3, 1, 10'd116, 10'd344);

      fire_shot(1'b1);
      snap(4'b1111, 3'd3, 1, 10'd216, 10'd440);
      bus.hit_valid = 1'b1;
      bus.hit_idx   = 2'd2;
      cyc();
      bus.hit_valid = 1'b0;
      snap(4'b1011, 3'd4, 2, 10'd116, 10'd372);

      // mid-flight reset with fire held through release
      d_reset_n    = 1'b0;
      bus.fire_req = 1'b1;
      snap(4'b0000, 3'd0, 0, 10'd0, 10'd0);
      cyc();
      d_reset_n = 1'b1;
      repeat (3) cyc();
      snap(4'b0000, 3'd0, 0, 10'd0, 10'd0);
      bus.fire_req = 1'b0;
      cyc();
      bus.ship_x = 10'd300;
      fire_shot(1'b1);
      snap(4'b0001, 3'd0, 0, 10'd316, 10'd440);

      // top edge: 440 - 109*4 = 4, then 0 still live, then retired
      tick(109);
      snap(4'b0001, 3'd1, 0, 10'd316, 10'd4);
      tick(1);
      snap(4'b0001, 3'd1, 0, 10'd316, 10'd0);
      tick(1);
      snap(4'b0000, 3'd1, 0, 10'd316, 10'd0);
      snap(4'b0000, 3'd0, 0, 10'd316, 10'd0);

      repeat (3) cyc();
      n_cmp += 2;
      if (pulse_q.size() != 0) begin
         n_bad++;
         $display("FAIL pulse_missing: %0d expected pulses never seen, required 0", pulse_q.size());
      end
      if (snap_q.size() != 0) begin
         n_bad++;
         $display("FAIL snap_pending: %0d snapshots unchecked, required 0", snap_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
